// File: rtl/dmem_req_ctrl.sv
// Data-memory request sequencer: one M-stage load/store in flight on a req/addr_ok/data_ok bus.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_req_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    input  logic        ext_stall,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        bus_err_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    // state | meaning
    // IDLE  | not busy, accepts a new access
    // REQ   | data_req high, waiting for addr_ok
    // WAIT  | address taken, waiting for data_ok
    // DONE  | result presented, waiting for the pipeline to advance
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        drop_q, drop_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic accept;
    logic busy;
    logic bus_done;
    logic drop_eff;
    logic tmo_expire;

    function automatic logic [1:0] store_size(input logic [3:0] wen);
        case (wen)
            4'b1111:                            store_size = 2'd2;
            4'b1100, 4'b0011:                   store_size = 2'd1;
            4'b1000, 4'b0100, 4'b0010, 4'b0001: store_size = 2'd0;
            default:                            store_size = 2'd2;
        endcase
    endfunction

    assign accept   = mem_en & ~flush;
    assign busy     = (state_q == S_REQ) | (state_q == S_WAIT);
    assign bus_done = ((state_q == S_REQ) & data_addr_ok & data_data_ok)
                    | ((state_q == S_WAIT) & data_data_ok);
    // A flush arriving together with the final data_ok still discards the result.
    assign drop_eff = drop_q | flush;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        req_d   = req_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    req_d   = 1'b1;
                    wstrb_d = mem_wen;
                    wdata_d = mem_wdata;
                    if (mem_wen == 4'b0000) begin
                        wr_d   = 1'b0;
                        size_d = 2'd2;
                        addr_d = {mem_addr[31:2], 2'b00};
                    end else begin
                        wr_d   = 1'b1;
                        size_d = store_size(mem_wen);
                        addr_d = mem_addr;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                if ((state_q == S_REQ) && data_addr_ok) begin
                    req_d = 1'b0;
                end
                if (bus_done || tmo_expire) begin
                    state_d = drop_eff ? S_IDLE : S_DONE;
                    drop_d  = 1'b0;
                    if (!bus_done) begin
                        req_d   = 1'b0;
                        rdata_d = 32'd0;
                    end else if (!wr_q && !drop_eff) begin
                        rdata_d = data_rdata;
                    end
                end else begin
                    drop_d = drop_eff;
                    if ((state_q == S_REQ) && data_addr_ok) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                if (!ext_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       bus_err_q, bus_err_d;

    // Down-counter loaded on REQ entry; the busy cycle that sees zero is the last one allowed.
    assign tmo_expire = busy & (tmo_cnt_q == 8'd0);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        bus_err_d = bus_err_q;
        if ((state_q == S_IDLE) && accept) begin
            tmo_cnt_d = TMO_LOAD;
            bus_err_d = 1'b0;
        end else if (busy) begin
            if (tmo_cnt_q != 8'd0) begin
                tmo_cnt_d = tmo_cnt_q - 8'd1;
            end
            if (tmo_expire && !bus_done) begin
                bus_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign tmo_expire = 1'b0;
    // Watchdog compiled out; the limit is referenced only so the parameter list stays uniform.
    assign bus_err_o  = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    assign stall_o = ((state_q == S_IDLE) & accept)
                   | (state_q == S_REQ)
                   | ((state_q == S_WAIT) & (~drop_q | mem_en));

    assign rdata_o    = rdata_q;
    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl; inputs change 1 time unit after the rising edge, outputs are checked on the falling edge.
module tb_dmem_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        ext_stall;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        bus_err_o;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks = 0;
    int errors = 0;

    dmem_req_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .ext_stall    (ext_stall),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .bus_err_o    (bus_err_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [3:0] wen_tab  [6] = '{4'b1111, 4'b1100, 4'b1000, 4'b0001, 4'b0110, 4'b0101};
    logic [1:0] size_tab [6] = '{2'd2,    2'd1,    2'd0,    2'd0,    2'd2,    2'd2};

    initial begin
        resetn = 1'b0; mem_en = 1'b0; mem_wen = 4'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        flush = 1'b0; ext_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        smp(); smp();
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_size", 32'(data_size), 32'd0);
        chk("rst_buserr", 32'(bus_err_o), 32'd0);
        cyc(); resetn = 1'b1;
        cyc();

        // flushed instruction in IDLE never issues
        mem_en = 1'b1; flush = 1'b1; smp();
        chk("flush_idle_stall", 32'(stall_o), 32'd0);
        cyc(); mem_en = 1'b0; flush = 1'b0; smp();
        chk("flush_idle_noreq", 32'(data_req), 32'd0);

        // best-case load at 0x1003
        cyc(); mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h1003; smp();
        chk("ld_c0_stall", 32'(stall_o), 32'd1);
        chk("ld_c0_req", 32'(data_req), 32'd0);
        cyc(); data_addr_ok = 1'b1; smp();
        chk("ld_c1_req", 32'(data_req), 32'd1);
        chk("ld_c1_addr", data_addr, 32'h1000);
        chk("ld_c1_size", 32'(data_size), 32'd2);
        chk("ld_c1_wr", 32'(data_wr), 32'd0);
        chk("ld_c1_wstrb", 32'(data_wstrb), 32'd0);
        chk("ld_c1_stall", 32'(stall_o), 32'd1);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF; smp();
        chk("ld_c2_stall", 32'(stall_o), 32'd1);
        chk("ld_c2_req", 32'(data_req), 32'd0);
        cyc(); data_data_ok = 1'b0; data_rdata = 32'd0; smp();
        chk("ld_c3_stall", 32'(stall_o), 32'd0);
        chk("ld_c3_rdata", rdata_o, 32'hDEADBEEF);
        cyc(); mem_en = 1'b0; smp();
        chk("ld_c4_idle_stall", 32'(stall_o), 32'd0);
        chk("ld_c4_rdata_hold", rdata_o, 32'hDEADBEEF);

        // halfword store, addr_ok and data_ok together
        cyc(); mem_en = 1'b1; mem_wen = 4'b0011; mem_addr = 32'h2002; mem_wdata = 32'h12341234; smp();
        chk("sth_c0_stall", 32'(stall_o), 32'd1);
        cyc(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h99999999; smp();
        chk("sth_c1_wr", 32'(data_wr), 32'd1);
        chk("sth_c1_size", 32'(data_size), 32'd1);
        chk("sth_c1_wstrb", 32'(data_wstrb), 32'h3);
        chk("sth_c1_addr", data_addr, 32'h2002);
        chk("sth_c1_wdata", data_wdata, 32'h12341234);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0; smp();
        chk("sth_c2_done_stall", 32'(stall_o), 32'd0);
        chk("sth_c2_req", 32'(data_req), 32'd0);
        chk("sth_c2_rdata_keep", rdata_o, 32'hDEADBEEF);
        cyc(); mem_en = 1'b0;

        // byte store, addr_ok delayed 5 cycles; stray data_ok in REQ ignored
        cyc(); mem_en = 1'b1; mem_wen = 4'b0100; mem_addr = 32'h3001; mem_wdata = 32'hA5A5A5A5; smp();
        for (int i = 0; i < 5; i++) begin
            cyc();
            mem_addr = 32'hFFFF_FFF0 + 32'(i);
            data_data_ok = (i == 2);
            smp();
            chk("stb_req_hold", 32'(data_req), 32'd1);
            chk("stb_addr_hold", data_addr, 32'h3001);
            chk("stb_size_hold", 32'(data_size), 32'd0);
            chk("stb_wstrb_hold", 32'(data_wstrb), 32'h4);
            chk("stb_stall_hold", 32'(stall_o), 32'd1);
        end
        cyc(); data_data_ok = 1'b0; data_addr_ok = 1'b1; smp();
        chk("stb_req_at_aok", 32'(data_req), 32'd1);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; smp();
        chk("stb_wait_req", 32'(data_req), 32'd0);
        chk("stb_wait_stall", 32'(stall_o), 32'd1);
        cyc(); data_data_ok = 1'b0; smp();
        chk("stb_done_stall", 32'(stall_o), 32'd0);
        cyc(); mem_en = 1'b0;

        // store size decode table
        for (int k = 0; k < 6; k++) begin
            cyc(); mem_en = 1'b1; mem_wen = wen_tab[k]; mem_addr = 32'h100 + 32'(k);
            cyc(); data_addr_ok = 1'b1; data_data_ok = 1'b1; smp();
            chk("tab_size", 32'(data_size), 32'(size_tab[k]));
            chk("tab_wstrb", 32'(data_wstrb), 32'(wen_tab[k]));
            cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b0; smp();
            chk("tab_done", 32'(stall_o), 32'd0);
            cyc(); mem_en = 1'b0;
        end

        // flush in WAIT: result dropped, no DONE cycle
        cyc(); mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h4000;
        cyc(); data_addr_ok = 1'b1;
        cyc(); data_addr_ok = 1'b0; flush = 1'b1; smp();
        chk("fl_wait_stall", 32'(stall_o), 32'd1);
        cyc(); flush = 1'b0; mem_addr = 32'h5000; smp();
        chk("fl_drop_stall_memen", 32'(stall_o), 32'd1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D; smp();
        chk("fl_dataok_stall", 32'(stall_o), 32'd1);
        cyc(); data_data_ok = 1'b0; data_rdata = 32'd0; smp();
        chk("fl_idle_stall", 32'(stall_o), 32'd1);
        chk("fl_idle_req", 32'(data_req), 32'd0);
        chk("fl_rdata_keep", rdata_o, 32'hDEADBEEF);
        cyc(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BADF00D; smp();
        chk("fl_next_req", 32'(data_req), 32'd1);
        chk("fl_next_addr", data_addr, 32'h5000);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0; ext_stall = 1'b1; smp();
        chk("es_done_stall", 32'(stall_o), 32'd0);
        chk("es_done_rdata", rdata_o, 32'h0BADF00D);

        // ext_stall holds DONE for 3 cycles
        for (int i = 0; i < 2; i++) begin
            cyc(); smp();
            chk("es_hold_stall", 32'(stall_o), 32'd0);
            chk("es_hold_rdata", rdata_o, 32'h0BADF00D);
            chk("es_hold_req", 32'(data_req), 32'd0);
        end
        cyc(); ext_stall = 1'b0; smp();
        chk("es_release_req", 32'(data_req), 32'd0);
        cyc(); mem_addr = 32'h6000; smp();
        chk("es_next_idle_stall", 32'(stall_o), 32'd1);
        chk("es_next_idle_req", 32'(data_req), 32'd0);
        cyc(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h11223344; smp();
        chk("es_next_req", 32'(data_req), 32'd1);
        chk("es_next_addr", data_addr, 32'h6000);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b0; smp();
        chk("es_next_rdata", rdata_o, 32'h11223344);
        chk("buserr_default", 32'(bus_err_o), 32'd0);
        cyc(); mem_en = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        // watchdog: no bus response
        cyc(); mem_en = 1'b1; mem_addr = 32'h7000;
        for (int i = 0; i < 4; i++) begin
            cyc(); smp();
            chk("tmo_busy_req", 32'(data_req), 32'd1);
        end
        cyc(); smp();
        chk("tmo_done_stall", 32'(stall_o), 32'd0);
        chk("tmo_buserr", 32'(bus_err_o), 32'd1);
        chk("tmo_rdata", rdata_o, 32'd0);
        chk("tmo_req_drop", 32'(data_req), 32'd0);
        cyc(); mem_en = 1'b0;
`endif

        // asynchronous reset mid-transaction
        cyc(); mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h8000;
        cyc(); smp();
        chk("arst_pre_req", 32'(data_req), 32'd1);
        #2; resetn = 1'b0; mem_en = 1'b0; #1;
        chk("arst_req", 32'(data_req), 32'd0);
        chk("arst_stall", 32'(stall_o), 32'd0);
        chk("arst_rdata", rdata_o, 32'd0);
        chk("arst_addr", data_addr, 32'd0);
        cyc(); resetn = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_req_ctrl.md
# dmem_req_ctrl

Sequencer between the memory-stage load/store datapath and an SRAM-like data bus with `req`/`addr_ok`/`data_ok` handshakes. It accepts one M-stage access, stalls the pipeline while it is outstanding, and derives the bus transfer size and strobes from the byte-enable pattern produced by the store formatter. It returns the raw 32-bit read word, which the load extractor then aligns. Exactly one access is in flight at a time.

## Interface
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles, used only with `DMEM_TIMEOUT_EN`. Range 1–255.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `mem_en` in 1: M-stage instruction is a load or store.
- `mem_wen` in 4: byte enables (0000 = load); bit 3 is the lane for addr[1:0]=00.
- `mem_addr` in 32: byte address (ALU result).
- `mem_wdata` in 32: lane-replicated store data.
- `flush` in 1: exception or flush of the M-stage instruction.
- `ext_stall` in 1: pipeline held by another source.
- `stall_o` out 1: hold the pipeline.
- `rdata_o` out 32: read word, valid while the state is DONE.
- `bus_err_o` out 1: watchdog expiry flag; constant 0 without the macro.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2, `data_addr` out 32, `data_wstrb` out 4, `data_wdata` out 32: bus request channel.
- `data_addr_ok` in 1, `data_data_ok` in 1, `data_rdata` in 32: bus response.

## Operation
- States and outputs:
  - IDLE: not busy.
  - REQ: `data_req`=1, waiting for `addr_ok`.
  - WAIT: waiting for `data_ok`.
  - DONE: result presented to the pipeline.
- Internal flag `drop` marks an access whose result must be discarded.
- IDLE:
  - On `mem_en & !flush`, latch the access and go to REQ.
  - A flushed instruction never issues.
- Latched fields:
  - Loads: `data_wr`=0, size=2, `data_addr`={addr[31:2],2'b00}, `data_wstrb`=0000.
  - Stores: `data_wr`=1, `data_addr`=byte address, `data_wstrb`=`mem_wen`.
  - Store size: 1111→2; 1100 or 0011→1; 1000, 0100, 0010 or 0001→0; any other pattern→2 with the strobes passed through unchanged.
- REQ:
  - `data_req` stays high and the request fields stay stable until `addr_ok`.
  - Request withdrawal is forbidden, even on `flush`.
  - `addr_ok & data_ok` in the same cycle → DONE (→IDLE if `drop`).
  - `addr_ok` alone → WAIT.
- WAIT: `data_ok` → DONE (→IDLE if `drop`). `rdata_o` captures `data_rdata` on that edge (loads only; stores leave it unchanged).
- `flush` in REQ or WAIT sets `drop`. The transaction completes on the bus, its data is discarded, and DONE is skipped.
- DONE: `stall_o`=0. Leave to IDLE when `!ext_stall`, otherwise hold DONE and `rdata_o`.
- `stall_o` = (IDLE & `mem_en` & !`flush`) | REQ | (WAIT & !`drop`) | (REQ/WAIT with `drop` while `mem_en`).
- The drop term blocks a new access until the bus is free.
- Reset values: state IDLE, `drop`=0, `data_req`=0, `data_wr`=0, `data_size`=0, `data_addr`=0, `data_wstrb`=0, `data_wdata`=0, `rdata_o`=0, `bus_err_o`=0, `stall_o`=0 (given `mem_en`=0).

## Timing
- `stall_o` is combinational from `mem_en` in IDLE (same cycle). All bus outputs are registered.
- Best-case load, cycles relative to `mem_en` at c0:
  - c1: REQ, `addr_ok`.
  - c2: WAIT, `data_ok`.
  - c3: DONE with `stall_o`=0; the instruction advances at the end of c3.
- With `addr_ok` and `data_ok` together in c1, DONE is c2.
- IDLE is re-entered one cycle after DONE, so the next access issues no earlier than 2 cycles after the previous DONE.
- `data_ok` arriving in REQ without `addr_ok` is ignored.
- `resetn` low mid-transaction returns to IDLE immediately. Bus state after reset is the bus owner's responsibility.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on REQ entry and counts each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`: force the next state to DONE (IDLE if `drop`), `rdata_o`=0, `bus_err_o`=1.
  - `bus_err_o` clears on the next REQ entry or on reset.
- `DMEM_TIMEOUT_EN` undefined: no counter, `bus_err_o` tied to 0, and the controller waits indefinitely.

## Test plan
- Load, addr 0x1003, `addr_ok` at c1, `data_ok` at c2 with rdata 0xDEADBEEF → `data_addr`=0x1000, size=2; stall c0–c2; `rdata_o`=0xDEADBEEF at c3; `stall_o`=0 at c3.
- Store, `wen`=0011, addr 0x2002, `addr_ok`+`data_ok` at c1 → `data_wr`=1, size=1, strobes 0011; DONE at c2.
- Store, `wen`=0100, `addr_ok` delayed 5 cycles → `data_req` stays high and fields stay stable for 5 cycles; size=0.
- `flush` in WAIT → stays busy until `data_ok`, then goes to IDLE with no DONE cycle; `rdata_o` unchanged.
- `ext_stall`=1 for 3 cycles in DONE → DONE held and `rdata_o` stable; a new `mem_en` is not issued until the cycle after release.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no `data_ok` → DONE after 4 busy cycles, `bus_err_o`=1, `rdata_o`=0.
